axi_arbiter: RTL

Two-master, one-slave AXI4-Lite-style arbiter sharing the single memory port between the instruction fetch unit (read-only master) and the load/store unit (read/write master). It sits between IFU/LSU and the memory/SRAM slave, grants the port to one master per transaction, and routes that master's channels through while the other master's handshakes are held off. It supports one outstanding transaction at a time.

---
 rtl/axi_arbiter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI4-Lite-style slave port between the IFU (read-only)
// and the LSU (read/write). One transaction is in flight at a time; the
// granted master's channels are routed through and the other master is held
// off until the FSM returns to IDLE.
//
// Build option: define ARB_ROUND_ROBIN_EN to break IFU/LSU ties in favour of
// the master that was not granted last. Without it, LSU always wins a tie.
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU read master
  input  logic                  ifu_arvalid,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  output logic                  ifu_arready,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic [1:0]            ifu_rresp,
  // LSU read/write master
  input  logic                  lsu_arvalid,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic [2:0]            lsu_arsize,
  output logic                  lsu_arready,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [1:0]            lsu_rresp,
  input  logic                  lsu_awvalid,
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic [2:0]            lsu_awsize,
  output logic                  lsu_awready,
  input  logic                  lsu_wvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_wready,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  output logic [1:0]            lsu_bresp,
  // Slave port
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic [2:0]            s_arsize,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic [2:0]            s_awsize,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [1:0]            s_bresp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_e;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // IFU fetches are always 32-bit instruction words.
  localparam logic [2:0] IFU_ARSIZE = 3'b010;

  state_e state_q, state_d;
  logic   addr_done_q, addr_done_d;
  logic   w_done_q, w_done_d;
  logic   last_grant_q, last_grant_d;

  logic   ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic   wr_both_done;
  logic   lsu_req, tie_to_lsu, pick_lsu;

  // Handshake detection, built from inputs and state only so the output
  // decode below never feeds back into itself.
  always_comb begin
    ar_hs = 1'b0;
    r_hs  = 1'b0;
    aw_hs = 1'b0;
    w_hs  = 1'b0;
    b_hs  = 1'b0;
    case (state_q)
      IFU_RD: begin
        ar_hs = ifu_arvalid & ~addr_done_q & s_arready;
        r_hs  = s_rvalid & ifu_rready;
      end
      LSU_RD: begin
        ar_hs = lsu_arvalid & ~addr_done_q & s_arready;
        r_hs  = s_rvalid & lsu_rready;
      end
      LSU_WR: begin
        aw_hs = lsu_awvalid & ~addr_done_q & s_awready;
        w_hs  = lsu_wvalid & ~w_done_q & s_wready;
      end
      default: ;
    endcase
    // B is only accepted once both AW and W are done (or finish this cycle).
    wr_both_done = (addr_done_q | aw_hs) & (w_done_q | w_hs);
    b_hs = (state_q == LSU_WR) & wr_both_done & s_bvalid & lsu_bready;
  end

  // Tie-break between IFU and LSU when both request in IDLE.
  always_comb begin
    lsu_req = lsu_awvalid | lsu_arvalid;
`ifdef ARB_ROUND_ROBIN_EN
    tie_to_lsu = (last_grant_q == GNT_IFU);
`else
    tie_to_lsu = 1'b1;
`endif
    pick_lsu = lsu_req & (~ifu_arvalid | tie_to_lsu);
  end

  // Next-state and flag update: arbitrate in IDLE, track handshakes otherwise.
  always_comb begin
    state_d      = state_q;
    addr_done_d  = addr_done_q;
    w_done_d     = w_done_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        addr_done_d = 1'b0;
        w_done_d    = 1'b0;
        if (pick_lsu) begin
          // An LSU write always beats an LSU read.
          state_d      = lsu_awvalid ? LSU_WR : LSU_RD;
          last_grant_d = GNT_LSU;
        end else if (ifu_arvalid) begin
          state_d      = IFU_RD;
          last_grant_d = GNT_IFU;
        end
      end
      IFU_RD, LSU_RD: begin
        if (ar_hs) addr_done_d = 1'b1;
        if (r_hs) begin
          state_d     = IDLE;
          addr_done_d = 1'b0;
        end
      end
      LSU_WR: begin
        if (aw_hs) addr_done_d = 1'b1;
        if (w_hs)  w_done_d    = 1'b1;
        if (b_hs) begin
          state_d     = IDLE;
          addr_done_d = 1'b0;
          w_done_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and transaction flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_done_q  <= 1'b0;
      w_done_q     <= 1'b0;
      last_grant_q <= GNT_IFU;
    end else begin
      state_q      <= state_d;
      addr_done_q  <= addr_done_d;
      w_done_q     <= w_done_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Channel routing: only the granted master sees slave readies/valids.
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    // Read address mux defaults to the IFU path (don't-care when idle).
    s_araddr    = ifu_araddr;
    s_arsize    = IFU_ARSIZE;
    case (state_q)
      IFU_RD: begin
        s_arvalid   = ifu_arvalid & ~addr_done_q;
        ifu_arready = s_arready & ~addr_done_q;
        ifu_rvalid  = s_rvalid;
        s_rready    = ifu_rready;
      end
      LSU_RD: begin
        s_araddr    = lsu_araddr;
        s_arsize    = lsu_arsize;
        s_arvalid   = lsu_arvalid & ~addr_done_q;
        lsu_arready = s_arready & ~addr_done_q;
        lsu_rvalid  = s_rvalid;
        s_rready    = lsu_rready;
      end
      LSU_WR: begin
        s_awvalid   = lsu_awvalid & ~addr_done_q;
        lsu_awready = s_awready & ~addr_done_q;
        s_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_wready  = s_wready & ~w_done_q;
        lsu_bvalid  = s_bvalid & wr_both_done;
        s_bready    = lsu_bready & wr_both_done;
      end
      default: ;
    endcase
  end

  // Write channel payload has a single source; response payloads broadcast.
  assign s_awaddr  = lsu_awaddr;
  assign s_awsize  = lsu_awsize;
  assign s_wdata   = lsu_wdata;
  assign s_wstrb   = lsu_wstrb;
  assign ifu_rdata = s_rdata;
  assign lsu_rdata = s_rdata;
  assign ifu_rresp = s_rresp;
  assign lsu_rresp = s_rresp;
  assign lsu_bresp = s_bresp;

endmodule
